inst_mem_loader: RTL and testbench
==================================

# inst_mem_loader

Parametrised, loadable instruction memory for the single-cycle/pipelined CPU fetch stage. On reset it fills every word with the NOP encoding. It then accepts a program image over a valid/ready load port and serves registered, stallable instruction fetches. It replaces the hard-wired 64-word instruction memory and allows program reload without resynthesis.

## Interface
Parameters:
- `DATA_W`, 32: instruction width in bits.
- `ADDR_W`, 6: word-address width; `DEPTH = 2**ADDR_W` is a derived localparam.
- `NOP_WORD`, `32'b00000000000001111000000000000000`: clear/default word; width `DATA_W`.

Ports:
- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  load word present.
- `load_ready`  out  1  block accepts load word this cycle.
- `load_data`  in  `DATA_W`  program word.
- `load_last`  in  1  qualifies final word of image.
- `reload`  in  1  in RUN, restart loading at address 0 without clearing.
- `fetch_en`  in  1  fetch request; low means stall.
- `fetch_addr`  in  `ADDR_W`  word address.
- `fetch_data`  out  `DATA_W`  registered instruction.
- `fetch_valid`  out  1  `fetch_data` updated by a fetch accepted last cycle.
- `busy`  out  1  high in CLEAR or LOAD.
- `load_count`  out  `ADDR_W+1`  words written in current load; saturates at `DEPTH`.
- `load_overflow`  out  1  sticky: image exceeded `DEPTH`.

## Operation
States are CLEAR, LOAD and RUN.

- **Reset values:** state=CLEAR, clear pointer=0, write pointer=0, `fetch_data=NOP_WORD`, `fetch_valid=0`, `load_ready=0`, `busy=1`, `load_count=0`, `load_overflow=0`.
- **CLEAR:**
  - Writes `NOP_WORD` to `mem[clr_ptr]` each cycle and increments the pointer.
  - After the write to `DEPTH-1`, goes to LOAD.
  - `load_valid` and `fetch_en` are ignored.
- **LOAD:**
  - `load_ready=1`.
  - On handshake (`load_valid && load_ready`):
    - While `load_count < DEPTH`: write `load_data` to `mem[wr_ptr]`, increment `wr_ptr` and `load_count`.
    - Otherwise: discard the word and set `load_overflow`.
  - A handshake with `load_last=1` (including a discarded word) moves to RUN.
  - `fetch_en` is ignored.
- **RUN:**
  - `busy=0`, `load_ready=0`.
  - When `fetch_en=1`: `fetch_data <= mem[fetch_addr]` and `fetch_valid <= 1`.
  - When `fetch_en=0`: `fetch_data` holds and `fetch_valid <= 0`.
  - `reload=1` moves to LOAD and zeroes `wr_ptr`, `load_count` and `load_overflow`. Existing contents are kept; only overwritten words change.
- **`reload` outside RUN:** ignored.
- **Simultaneous `reload` and `fetch_en` in RUN:** the fetch completes normally, then the state moves to LOAD.
- **`rst` in any state:** forces the reset values and re-runs CLEAR. A partial load is discarded.

## Timing
- CLEAR lasts exactly `DEPTH` cycles after the first cycle with `rst=0`. `load_ready` first rises in cycle `DEPTH+1`.
- Load throughput is one word per cycle. There is no back-pressure inside LOAD.
- The state becomes RUN on the clock edge that accepts the last word. A fetch may be issued in the next cycle.
- Fetch latency is 1 cycle, from the `fetch_en`/`fetch_addr` sample to `fetch_data`/`fetch_valid`.
- A fetch of the address written on the final load edge returns the new word.
- There is no read-during-write case, because fetches are only accepted in RUN.

## Structure
- **Package `inst_mem_pkg`:** state enum `imem_state_e` {CLEAR, LOAD, RUN} and the default NOP constant `IMEM_NOP`, used as the `NOP_WORD` default.
- **Sub-module `inst_mem_array`:** simple dual-port RAM with one synchronous write port and one synchronous registered read port with read enable, parametrised by `DATA_W`/`ADDR_W`.
- **Controller (top):** FSM, pointers, counters and output registers.

## Test plan
- **Reset then clear:** deassert `rst` and hold `load_valid=1`. Required: `busy=1`/`load_ready=0` for 64 cycles, no writes during that time, `load_ready=1` in cycle 65.
- **Load and fetch:** load 10 words, word1=`32'h80080001`, `load_last` on word 9. Required: `load_count=10`, RUN entered. Fetch addr 1 → `32'h80080001` with `fetch_valid=1` one cycle later. Fetch addr 10 → `NOP_WORD`.
- **Stall:** in RUN, fetch addr 1, then hold `fetch_en=0` for 3 cycles while changing `fetch_addr`. Required: `fetch_data` stays `32'h80080001` and `fetch_valid=0` for those cycles.
- **Overflow:** load 66 words (value = index) with `load_last` on the 66th. Required: `load_count=64`, `load_overflow=1`, RUN entered, addr 0 reads 0, addr 63 reads 63.
- **Reload:** in RUN, pulse `reload`, then load 2 words (`32'hA`, `32'hB`) with last. Required: addr 0/1 read A/B, addr 5 keeps its prior value, `load_overflow=0`.
- **Reset mid-load:** after 3 load words, assert `rst` for 1 cycle. Required: CLEAR for 64 cycles, then a new 1-word load. Addr 1 and addr 2 read `NOP_WORD`.

Source files
------------

// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the loadable instruction memory.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } imem_state_e;

  // Encoding used to fill every word on reset.
  localparam logic [31:0] IMEM_NOP = 32'b00000000000001111000000000000000;

endpackage

// File: rtl/inst_mem_loader_array.sv
// Simple dual-port RAM: synchronous write port, registered read port with
// read enable. The read register resets to RD_RST_VAL.
module inst_mem_array #(
  parameter int                 DATA_W     = 32,
  parameter int                 ADDR_W     = 6,
  parameter logic [DATA_W-1:0]  RD_RST_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];
  logic [DATA_W-1:0] rdata_r;

  // Storage write port; contents are not reset, the controller clears them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; holds its value while re is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= RD_RST_VAL;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/inst_mem_loader.sv
// Loadable instruction memory: clears to NOP after reset, accepts a program
// image over a valid/ready port, then serves registered stallable fetches.
module inst_mem_loader
  import inst_mem_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 6,
  parameter logic [DATA_W-1:0] NOP_WORD = IMEM_NOP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              reload,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              busy,
  output logic [ADDR_W:0]   load_count,
  output logic              load_overflow
);

  localparam int             DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  imem_state_e       state_r, next_state_s;
  logic [ADDR_W-1:0] clr_ptr_r, wr_ptr_r;
  logic [ADDR_W:0]   load_count_r;
  logic              load_overflow_r, fetch_valid_r, busy_r, load_ready_r;
  logic              busy_s, load_ready_s, handshake_s, room_s;
  logic              we_s, re_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [DATA_W-1:0] wdata_s;

  assign handshake_s = load_valid && load_ready_r;
  assign room_s      = (load_count_r < DEPTH_C);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CLEAR;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      CLEAR: begin
        if (clr_ptr_r == {ADDR_W{1'b1}}) next_state_s = LOAD;
        else                             next_state_s = CLEAR;
      end
      LOAD: begin
        if (handshake_s && load_last) next_state_s = RUN;
        else                          next_state_s = LOAD;
      end
      RUN: begin
        if (reload) next_state_s = LOAD;
        else        next_state_s = RUN;
      end
      default: next_state_s = CLEAR;
    endcase
  end

  // Output decode: next-cycle flags and RAM port controls.
  always_comb begin
    busy_s       = (next_state_s != RUN);
    load_ready_s = (next_state_s == LOAD);
    we_s         = 1'b0;
    waddr_s      = clr_ptr_r;
    wdata_s      = NOP_WORD;
    re_s         = (state_r == RUN) && fetch_en;
    case (state_r)
      CLEAR: begin
        we_s = !rst;
      end
      LOAD: begin
        if (handshake_s && room_s) begin
          we_s    = !rst;
          waddr_s = wr_ptr_r;
          wdata_s = load_data;
        end else begin
          we_s = 1'b0;
        end
      end
      default: begin
        we_s = 1'b0;
      end
    endcase
  end

  // Pointers, load bookkeeping and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_ptr_r       <= {ADDR_W{1'b0}};
      wr_ptr_r        <= {ADDR_W{1'b0}};
      load_count_r    <= {(ADDR_W+1){1'b0}};
      load_overflow_r <= 1'b0;
      fetch_valid_r   <= 1'b0;
      busy_r          <= 1'b1;
      load_ready_r    <= 1'b0;
    end else begin
      fetch_valid_r <= re_s;
      busy_r        <= busy_s;
      load_ready_r  <= load_ready_s;
      if (state_r == CLEAR) begin
        clr_ptr_r <= clr_ptr_r + ADDR_W'(1);
      end
      if (handshake_s) begin
        if (room_s) begin
          wr_ptr_r     <= wr_ptr_r + ADDR_W'(1);
          load_count_r <= load_count_r + (ADDR_W+1)'(1);
        end else begin
          load_overflow_r <= 1'b1;
        end
      end
      // Reload keeps memory contents; only the write bookkeeping restarts.
      if ((state_r == RUN) && reload) begin
        wr_ptr_r        <= {ADDR_W{1'b0}};
        load_count_r    <= {(ADDR_W+1){1'b0}};
        load_overflow_r <= 1'b0;
      end
    end
  end

  inst_mem_array #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .RD_RST_VAL (NOP_WORD)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .re    (re_s),
    .raddr (fetch_addr),
    .rdata (fetch_data)
  );

  assign load_ready    = load_ready_r;
  assign fetch_valid   = fetch_valid_r;
  assign busy          = busy_r;
  assign load_count    = load_count_r;
  assign load_overflow = load_overflow_r;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader: table-driven fetches
// plus hand-written sequences for clear, stall, overflow, reload and reset.
module tb_inst_mem_loader;

  localparam logic [31:0] NOP = 32'h00078000;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;
  logic        reload;
  logic        fetch_en;
  logic [5:0]  fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic        busy;
  logic [6:0]  load_count;
  logic        load_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] exp;
  } fvec_t;

  fvec_t ftab[5];

  inst_mem_loader dut (
    .clk           (clk),
    .rst           (rst),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_data     (load_data),
    .load_last     (load_last),
    .reload        (reload),
    .fetch_en      (fetch_en),
    .fetch_addr    (fetch_addr),
    .fetch_data    (fetch_data),
    .fetch_valid   (fetch_valid),
    .busy          (busy),
    .load_count    (load_count),
    .load_overflow (load_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic do_fetch(input string name, input logic [5:0] a, input logic [31:0] exp);
    fetch_en   = 1'b1;
    fetch_addr = a;
    tick();
    fetch_en   = 1'b0;
    check({name, "_data"}, fetch_data, exp);
    check({name, "_valid"}, {31'd0, fetch_valid}, 32'd1);
  endtask

  // Pulse rst for one cycle and return the cycle number in which load_ready rose.
  task automatic reset_and_wait(output int cyc);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 100; c++) begin
      if (load_ready) begin
        cyc = c;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int cyc;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 32'd0;
    load_last  = 1'b0;
    reload     = 1'b0;
    fetch_en   = 1'b0;
    fetch_addr = 6'd0;

    ftab[0] = '{addr: 6'd0,  exp: 32'h80080000};
    ftab[1] = '{addr: 6'd1,  exp: 32'h80080001};
    ftab[2] = '{addr: 6'd9,  exp: 32'h80080009};
    ftab[3] = '{addr: 6'd10, exp: NOP};
    ftab[4] = '{addr: 6'd63, exp: NOP};

    tick();
    tick();
    check("rst_busy",       {31'd0, busy},          32'd1);
    check("rst_ready",      {31'd0, load_ready},    32'd0);
    check("rst_fvalid",     {31'd0, fetch_valid},   32'd0);
    check("rst_fdata",      fetch_data,             NOP);
    check("rst_count",      {25'd0, load_count},    32'd0);
    check("rst_overflow",   {31'd0, load_overflow}, 32'd0);

    // Clear phase: load_valid and fetch_en held high must be ignored.
    rst        = 1'b0;
    load_valid = 1'b1;
    load_data  = 32'hBAD0BAD0;
    fetch_en   = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      check("clear_busy",  {31'd0, busy},        32'd1);
      check("clear_ready", {31'd0, load_ready},  32'd0);
      check("clear_fvalid", {31'd0, fetch_valid}, 32'd0);
      tick();
    end
    fetch_en = 1'b0;
    check("c65_ready", {31'd0, load_ready}, 32'd1);
    check("c65_count", {25'd0, load_count}, 32'd0);
    check("c65_fdata", fetch_data,          NOP);

    // Load a 10-word image.
    for (int i = 0; i < 10; i++) begin
      load_word(32'h80080000 | i, (i == 9));
    end
    check("load10_count", {25'd0, load_count},    32'd10);
    check("load10_busy",  {31'd0, busy},          32'd0);
    check("load10_ready", {31'd0, load_ready},    32'd0);
    check("load10_ovf",   {31'd0, load_overflow}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      do_fetch($sformatf("ftab%0d", i), ftab[i].addr, ftab[i].exp);
    end

    // Stall: data holds, valid drops, address changes ignored.
    do_fetch("stall_pre", 6'd1, 32'h80080001);
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 6'd5 + 6'(i);
      tick();
      check("stall_data",  fetch_data,           32'h80080001);
      check("stall_valid", {31'd0, fetch_valid}, 32'd0);
    end

    // Reload together with a fetch: the fetch completes, then LOAD.
    reload     = 1'b1;
    fetch_en   = 1'b1;
    fetch_addr = 6'd9;
    tick();
    reload   = 1'b0;
    fetch_en = 1'b0;
    check("rlf_data",  fetch_data,           32'h80080009);
    check("rlf_valid", {31'd0, fetch_valid}, 32'd1);
    check("rlf_ready", {31'd0, load_ready},  32'd1);
    check("rlf_busy",  {31'd0, busy},        32'd1);

    // Overflow: 66 words, words 64 and 65 discarded.
    for (int i = 0; i < 66; i++) begin
      load_word(32'(i), (i == 65));
      if (i == 63) begin
        check("ovf_at64_count", {25'd0, load_count},    32'd64);
        check("ovf_at64_flag",  {31'd0, load_overflow}, 32'd0);
      end
    end
    check("ovf_count", {25'd0, load_count},    32'd64);
    check("ovf_flag",  {31'd0, load_overflow}, 32'd1);
    check("ovf_busy",  {31'd0, busy},          32'd0);
    do_fetch("ovf_a0",  6'd0,  32'd0);
    do_fetch("ovf_a63", 6'd63, 32'd63);

    // Reload: clears overflow, keeps untouched words; reload in LOAD ignored.
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check("rl_ovf_clr", {31'd0, load_overflow}, 32'd0);
    check("rl_count0",  {25'd0, load_count},    32'd0);
    reload = 1'b1;
    load_word(32'hA, 1'b0);
    reload = 1'b0;
    check("rl_ign_count", {25'd0, load_count}, 32'd1);
    load_word(32'hB, 1'b1);
    check("rl_count2", {25'd0, load_count},    32'd2);
    check("rl_ovf",    {31'd0, load_overflow}, 32'd0);
    check("rl_busy",   {31'd0, busy},          32'd0);
    do_fetch("rl_a0", 6'd0, 32'hA);
    do_fetch("rl_a1", 6'd1, 32'hB);
    do_fetch("rl_a5", 6'd5, 32'd5);

    // Reset mid-load discards the partial image and re-clears.
    reload = 1'b1;
    tick();
    reload = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_word(32'hC0DE0000 | i, 1'b0);
    end
    check("mid_count3", {25'd0, load_count}, 32'd3);
    reset_and_wait(cyc);
    check("mid_clear_len", 32'(cyc), 32'd65);
    check("mid_fdata_rst", fetch_data,          NOP);
    check("mid_count_rst", {25'd0, load_count}, 32'd0);
    load_word(32'h00001234, 1'b1);
    check("mid_count1", {25'd0, load_count}, 32'd1);
    do_fetch("mid_a0", 6'd0, 32'h00001234);
    do_fetch("mid_a1", 6'd1, NOP);
    do_fetch("mid_a2", 6'd2, NOP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
